key_extractor: RTL and testbench

//  Stage directly downstream of the header parser. On the parser's ready_o, takes the
//  per-header base addresses (parsed_hdrs) and fetches up to NUM_FIELDS configured header

---
 rtl/key_extractor_pkg.sv | 37 +++
 rtl/key_extractor_field_table.sv | 34 +++
 rtl/key_extractor.sv | 149 ++++++++++++++
 tb/tb_key_extractor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_extractor_pkg.sv
// Shared definitions for the key extractor: FSM states, field descriptor layout and
// width helpers used when issuing and capturing field reads.
package key_extractor_pkg;

    localparam int          NUM_FIELDS_DEF = 4;
    localparam int          ADDR_W         = 32;
    localparam int          DATA_W         = 32;
    localparam logic [31:0] NO_HEADER      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        KE_STATE_FREE  = 2'd0,
        KE_STATE_FETCH = 2'd1,
        KE_STATE_DONE  = 2'd2
    } ke_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] hdr_id;
        logic [31:0] offset;
        logic [3:0]  width;
    } ke_desc_t;

    // Out-of-range widths (0 or above 4) read a full word.
    function automatic logic [3:0] eff_width(input logic [3:0] w);
        return (w == 4'd0 || w > 4'd4) ? 4'd4 : w;
    endfunction

    function automatic logic [DATA_W-1:0] width_mask(input logic [3:0] w);
        case (eff_width(w))
            4'd1:    return 32'h0000_00FF;
            4'd2:    return 32'h0000_FFFF;
            4'd3:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/key_extractor_field_table.sv
// Runtime-configurable field descriptors: one write port from the mod interface and one
// combinational indexed read port; indices past the table read as an invalid entry.
module key_extractor_field_table
    import key_extractor_pkg::*;
#(
    parameter int NUM_FIELDS = NUM_FIELDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_idx,
    input  ke_desc_t    wr_desc,
    input  logic [31:0] rd_idx,
    output ke_desc_t    rd_desc
);

    ke_desc_t entries [NUM_FIELDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FIELDS; i++) entries[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_FIELDS; i++)
                if (wr_idx == 32'(i)) entries[i] <= wr_desc;
        end
    end

    always_comb begin
        rd_desc = '0;
        for (int i = 0; i < NUM_FIELDS; i++)
            if (rd_idx == 32'(i)) rd_desc = entries[i];
    end

endmodule

// File: rtl/key_extractor.sv
// Fetches the configured header fields from packet memory, one slot per cycle, and packs
// them into a lookup key (slot 0 in the MSBs) with a matching field-present bitmap.
module key_extractor
    import key_extractor_pkg::*;
#(
    parameter int NUM_HEADERS = 2,
    parameter int NUM_FIELDS  = NUM_FIELDS_DEF,
    parameter int FIELD_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [32*NUM_HEADERS-1:0]     parsed_hdrs_i,
    output logic                          mem_ce_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [3:0]                    mem_width_o,
    output logic [DATA_W-1:0]             mem_data_o,
    input  logic [DATA_W-1:0]             mem_data_i,
    output logic                          ready_o,
    output logic [FIELD_W*NUM_FIELDS-1:0] key_o,
    output logic [NUM_FIELDS-1:0]         present_o,
    input  logic                          mod_start_i,
    input  logic [31:0]                   mod_field_idx_i,
    input  logic                          mod_valid_i,
    input  logic [31:0]                   mod_hdr_id_i,
    input  logic [31:0]                   mod_offset_i,
    input  logic [3:0]                    mod_width_i,
    output ke_state_t                     dbg_state
);

    ke_state_t                      state;
    logic [31:0]                    slot;
    logic [32*NUM_HEADERS-1:0]      hdrs;
    logic                           pend_fetch;
    logic [3:0]                     pend_width;

    logic [31:0]                    rd_idx;
    ke_desc_t                       rd_desc;
    ke_desc_t                       wr_desc;
    logic [32*NUM_HEADERS-1:0]      src_hdrs;
    logic [ADDR_W-1:0]              base;
    logic                           hdr_ok;
    logic                           issue_fetch;
    logic [ADDR_W-1:0]              issue_addr;
    logic [3:0]                     issue_width;

    assign mem_we_o   = 1'b0;
    assign mem_data_o = '0;
    assign dbg_state  = state;

    assign wr_desc = '{valid: mod_valid_i, hdr_id: mod_hdr_id_i,
                       offset: mod_offset_i, width: mod_width_i};

    key_extractor_field_table #(.NUM_FIELDS(NUM_FIELDS)) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mod_start_i && state == KE_STATE_FREE),
        .wr_idx  (mod_field_idx_i),
        .wr_desc (wr_desc),
        .rd_idx  (rd_idx),
        .rd_desc (rd_desc)
    );

    // The read port always looks at the slot about to be issued; on the start edge the
    // header bases come straight from the parser since they are only being latched then.
    always_comb begin
        rd_idx   = (state == KE_STATE_FETCH) ? slot + 32'd1 : 32'd0;
        src_hdrs = (state == KE_STATE_FREE) ? parsed_hdrs_i : hdrs;
        base     = NO_HEADER;
        hdr_ok   = 1'b0;
        for (int h = 0; h < NUM_HEADERS; h++) begin
            if (rd_desc.hdr_id == 32'(h)) begin
                base   = src_hdrs[(NUM_HEADERS-1-h)*32 +: 32];
                hdr_ok = 1'b1;
            end
        end
        issue_fetch = rd_desc.valid && hdr_ok && (base != NO_HEADER);
        issue_addr  = issue_fetch ? base + rd_desc.offset : '0;
        issue_width = issue_fetch ? eff_width(rd_desc.width) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= KE_STATE_FREE;
            slot        <= '0;
            hdrs        <= '0;
            pend_fetch  <= 1'b0;
            pend_width  <= '0;
            mem_ce_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_width_o <= '0;
            ready_o     <= 1'b0;
            key_o       <= '0;
            present_o   <= '0;
        end else begin
            case (state)
                KE_STATE_FREE: begin
                    if (!mod_start_i && start_i) begin
                        hdrs        <= parsed_hdrs_i;
                        key_o       <= '0;
                        present_o   <= '0;
                        ready_o     <= 1'b0;
                        slot        <= '0;
                        mem_ce_o    <= issue_fetch;
                        mem_addr_o  <= issue_addr;
                        mem_width_o <= issue_width;
                        pend_fetch  <= issue_fetch;
                        pend_width  <= issue_width;
                        state       <= KE_STATE_FETCH;
                    end
                end
                KE_STATE_FETCH: begin
                    // Slot 0 sits in the MSBs of both key_o and present_o.
                    for (int i = 0; i < NUM_FIELDS; i++) begin
                        if (pend_fetch && slot == 32'(i)) begin
                            key_o[(NUM_FIELDS-1-i)*FIELD_W +: FIELD_W] <=
                                FIELD_W'(mem_data_i & width_mask(pend_width));
                            present_o[NUM_FIELDS-1-i] <= 1'b1;
                        end
                    end
                    if (slot == 32'(NUM_FIELDS-1)) begin
                        mem_ce_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_width_o <= '0;
                        pend_fetch  <= 1'b0;
                        ready_o     <= 1'b1;
                        state       <= KE_STATE_DONE;
                    end else begin
                        slot        <= slot + 32'd1;
                        mem_ce_o    <= issue_fetch;
                        mem_addr_o  <= issue_addr;
                        mem_width_o <= issue_width;
                        pend_fetch  <= issue_fetch;
                        pend_width  <= issue_width;
                    end
                end
                KE_STATE_DONE: begin
                    if (!start_i) begin
                        ready_o <= 1'b0;
                        state   <= KE_STATE_FREE;
                    end
                end
                default: state <= KE_STATE_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_extractor.sv
// Directed bench for key_extractor: a table of descriptor configurations with hand-computed
// keys and access lists, plus sequences for mod/start priority, reset mid-fetch and wrap.
module tb_key_extractor;
    import key_extractor_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [63:0]   parsed_hdrs_i;
    logic          mem_ce_o, mem_we_o;
    logic [31:0]   mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]    mem_width_o;
    logic          ready_o;
    logic [127:0]  key_o;
    logic [3:0]    present_o;
    logic          mod_start_i, mod_valid_i;
    logic [31:0]   mod_field_idx_i, mod_hdr_id_i, mod_offset_i;
    logic [3:0]    mod_width_i;
    ke_state_t     dbg_state;

    always #5 clk = ~clk;

    key_extractor #(.NUM_HEADERS(2), .NUM_FIELDS(4), .FIELD_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .parsed_hdrs_i(parsed_hdrs_i),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .ready_o(ready_o), .key_o(key_o), .present_o(present_o),
        .mod_start_i(mod_start_i), .mod_field_idx_i(mod_field_idx_i),
        .mod_valid_i(mod_valid_i), .mod_hdr_id_i(mod_hdr_id_i),
        .mod_offset_i(mod_offset_i), .mod_width_i(mod_width_i), .dbg_state(dbg_state)
    );

    // Packet memory: word already right-aligned; junk above the field width must be masked.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction
    assign mem_data_i = mem_ce_o ? rd_mem(mem_addr_o) : 32'hA5A5_A5A5;

    typedef struct {
        ke_desc_t [3:0]        desc;
        logic [63:0]           hdrs;
        logic [127:0]          exp_key;
        logic [3:0]            exp_present;
        int                    n_acc;
        logic [3:0][31:0]      acc_addr;
        logic [3:0][3:0]       acc_width;
    } vec_t;

    vec_t vecs [5];
    vec_t v_tmp;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ke_desc_t mk(input logic v, input logic [31:0] h, input logic [31:0] o,
                                    input logic [3:0] w);
        ke_desc_t d;
        d.valid = v; d.hdr_id = h; d.offset = o; d.width = w;
        return d;
    endfunction

    task automatic prog(input int idx, input ke_desc_t d);
        mod_start_i = 1'b1; mod_field_idx_i = 32'(idx); mod_valid_i = d.valid;
        mod_hdr_id_i = d.hdr_id; mod_offset_i = d.offset; mod_width_i = d.width;
        step();
        mod_start_i = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int lat;
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (ready_o) begin lat = e; break; end
        end
        check({tag, "_latency"}, 128'(lat), 128'd4);
    endtask

    task automatic run_fetch(input vec_t v, input int hold, input string tag);
        logic [31:0] a_q[$];
        logic [3:0]  w_q[$];
        int          lat;
        logic        held_ok;
        parsed_hdrs_i = v.hdrs;
        start_i = 1'b1;
        step();
        check({tag, "_state_fetch"}, 128'(dbg_state), 128'(KE_STATE_FETCH));
        check({tag, "_ready_early"}, 128'(ready_o), 128'd0);
        if (mem_ce_o) begin a_q.push_back(mem_addr_o); w_q.push_back(mem_width_o); end
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (mem_ce_o) begin a_q.push_back(mem_addr_o); w_q.push_back(mem_width_o); end
            if (ready_o) begin lat = e; break; end
        end
        check({tag, "_latency"}, 128'(lat), 128'd4);
        check({tag, "_key"}, key_o, v.exp_key);
        check({tag, "_present"}, 128'(present_o), 128'(v.exp_present));
        check({tag, "_n_access"}, 128'(a_q.size()), 128'(v.n_acc));
        for (int j = 0; j < v.n_acc && j < a_q.size(); j++) begin
            check($sformatf("%s_addr%0d", tag, j), 128'(a_q[j]), 128'(v.acc_addr[j]));
            check($sformatf("%s_width%0d", tag, j), 128'(w_q[j]), 128'(v.acc_width[j]));
        end
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            if (!ready_o || mem_ce_o || dbg_state != KE_STATE_DONE || key_o !== v.exp_key)
                held_ok = 1'b0;
        end
        check({tag, "_hold_done"}, 128'(held_ok), 128'd1);
        start_i = 1'b0;
        step();
        check({tag, "_ready_drop"}, 128'(ready_o), 128'd0);
        check({tag, "_state_free"}, 128'(dbg_state), 128'(KE_STATE_FREE));
        check({tag, "_key_held"}, key_o, v.exp_key);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[32'h10C] = 32'h0000_0800;  mem[32'h117] = 32'h0000_0006;
        mem[32'h200] = 32'hCAFE_BABE;  mem[32'h304] = 32'h1234_5678;
        mem[32'h301] = 32'hFF11_2233;  mem[32'h002] = 32'hABCD_1234;
        mem[32'h010] = 32'h9988_7777;

        for (int i = 0; i < 5; i++) begin
            for (int s = 0; s < 4; s++) vecs[i].desc[s] = mk(1'b0, 32'd0, 32'd0, 4'd0);
            vecs[i].hdrs = 64'd0; vecs[i].exp_key = '0; vecs[i].exp_present = 4'b0000;
            vecs[i].n_acc = 0; vecs[i].acc_addr = '0; vecs[i].acc_width = '0;
        end
        // v0: two fields from two headers
        vecs[0].desc[0] = mk(1'b1, 32'd0, 32'd12, 4'd2);
        vecs[0].desc[1] = mk(1'b1, 32'd1, 32'd9, 4'd1);
        vecs[0].hdrs = {32'h100, 32'h10E};
        vecs[0].exp_key = {32'h0000_0800, 32'h0000_0006, 32'h0, 32'h0};
        vecs[0].exp_present = 4'b1100; vecs[0].n_acc = 2;
        vecs[0].acc_addr[0] = 32'h10C; vecs[0].acc_width[0] = 4'd2;
        vecs[0].acc_addr[1] = 32'h117; vecs[0].acc_width[1] = 4'd1;
        // v1: header 1 absent
        vecs[1] = vecs[0];
        vecs[1].hdrs = {32'h100, NO_HEADER};
        vecs[1].exp_key = {32'h0000_0800, 96'h0};
        vecs[1].exp_present = 4'b1000; vecs[1].n_acc = 1;
        // v2: everything invalid (plus out-of-range writes)
        // v3: width 0 normalises to 4, hdr id out of range, zero-extension of junk
        vecs[3].desc[0] = mk(1'b1, 32'd1, 32'd0, 4'd4);
        vecs[3].desc[1] = mk(1'b1, 32'd0, 32'd4, 4'd0);
        vecs[3].desc[2] = mk(1'b1, 32'd2, 32'd0, 4'd1);
        vecs[3].desc[3] = mk(1'b1, 32'd0, 32'd1, 4'd3);
        vecs[3].hdrs = {32'h300, 32'h200};
        vecs[3].exp_key = {32'hCAFE_BABE, 32'h1234_5678, 32'h0, 32'h0011_2233};
        vecs[3].exp_present = 4'b1101; vecs[3].n_acc = 3;
        vecs[3].acc_addr[0] = 32'h200; vecs[3].acc_width[0] = 4'd4;
        vecs[3].acc_addr[1] = 32'h304; vecs[3].acc_width[1] = 4'd4;
        vecs[3].acc_addr[2] = 32'h301; vecs[3].acc_width[2] = 4'd3;
        // v4: address wraps past 2^32
        vecs[4].desc[0] = mk(1'b1, 32'd0, 32'd4, 4'd2);
        vecs[4].desc[1] = mk(1'b1, 32'd1, 32'd0, 4'd1);
        vecs[4].hdrs = {32'hFFFF_FFFE, 32'h10};
        vecs[4].exp_key = {32'h0000_1234, 32'h0000_0077, 64'h0};
        vecs[4].exp_present = 4'b1100; vecs[4].n_acc = 2;
        vecs[4].acc_addr[0] = 32'h0000_0002; vecs[4].acc_width[0] = 4'd2;
        vecs[4].acc_addr[1] = 32'h0000_0010; vecs[4].acc_width[1] = 4'd1;

        rst = 1'b1; start_i = 1'b0; parsed_hdrs_i = '0; mod_start_i = 1'b0;
        mod_field_idx_i = '0; mod_valid_i = 1'b0; mod_hdr_id_i = '0;
        mod_offset_i = '0; mod_width_i = '0;
        step(); step();
        check("rst_ready", 128'(ready_o), 128'd0);
        check("rst_key", key_o, 128'd0);
        check("rst_present", 128'(present_o), 128'd0);
        check("rst_mem_ce", 128'(mem_ce_o), 128'd0);
        check("rst_mem_addr", 128'(mem_addr_o), 128'd0);
        check("rst_mem_width", 128'(mem_width_o), 128'd0);
        check("rst_mem_we", 128'(mem_we_o), 128'd0);
        check("rst_mem_data", 128'(mem_data_o), 128'd0);
        check("rst_state", 128'(dbg_state), 128'(KE_STATE_FREE));
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            for (int s = 0; s < 4; s++) prog(s, vecs[i].desc[s]);
            if (i == 2) begin
                prog(4, mk(1'b1, 32'd0, 32'd12, 4'd2));
                prog(5, mk(1'b1, 32'd1, 32'd9, 4'd1));
            end
            run_fetch(vecs[i], (i == 4) ? 5 : 2, $sformatf("v%0d", i));
        end

        // mod_start wins over start in FREE; mod writes during FETCH are dropped
        for (int s = 0; s < 4; s++) prog(s, mk(1'b0, 32'd0, 32'd0, 4'd0));
        parsed_hdrs_i = {32'h100, 32'h10E};
        start_i = 1'b1;
        mod_start_i = 1'b1; mod_field_idx_i = 32'd0; mod_valid_i = 1'b1;
        mod_hdr_id_i = 32'd0; mod_offset_i = 32'd12; mod_width_i = 4'd2;
        step();
        mod_start_i = 1'b0;
        check("pri_state_free", 128'(dbg_state), 128'(KE_STATE_FREE));
        check("pri_no_access", 128'(mem_ce_o), 128'd0);
        step();
        check("pri_state_fetch", 128'(dbg_state), 128'(KE_STATE_FETCH));
        check("pri_ce", 128'(mem_ce_o), 128'd1);
        check("pri_addr", 128'(mem_addr_o), 128'h10C);
        mod_start_i = 1'b1; mod_field_idx_i = 32'd1; mod_valid_i = 1'b1;
        mod_hdr_id_i = 32'd1; mod_offset_i = 32'd9; mod_width_i = 4'd1;
        wait_ready("pri");
        mod_start_i = 1'b0;
        check("pri_present", 128'(present_o), 128'b1000);
        start_i = 1'b0;
        step();
        v_tmp = vecs[1];
        v_tmp.hdrs = {32'h100, 32'h10E};
        run_fetch(v_tmp, 1, "pri2");

        // reset during the second FETCH cycle aborts and clears the table
        prog(1, mk(1'b1, 32'd1, 32'd9, 4'd1));
        parsed_hdrs_i = {32'h100, 32'h10E};
        start_i = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_state", 128'(dbg_state), 128'(KE_STATE_FREE));
        check("abort_ready", 128'(ready_o), 128'd0);
        check("abort_key", key_o, 128'd0);
        check("abort_present", 128'(present_o), 128'd0);
        check("abort_ce", 128'(mem_ce_o), 128'd0);
        rst = 1'b0; start_i = 1'b0;
        step();
        v_tmp = vecs[2];
        v_tmp.hdrs = {32'h100, 32'h10E};
        run_fetch(v_tmp, 1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
